// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file for the RV32I core.
// Commits the MEM/WB result into x1..x31 and serves two combinational
// source-operand reads with same-cycle write-to-read bypass. Also counts
// retired instructions (every non-bubble MEM/WB mnemonic) in a 64-bit counter.
module wb_regfile #(
  parameter logic [5:0] NOP_MNEMONIC = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_mnemonic,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_ALUout,
  input  logic        i_rd_wr,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [63:0] o_instret
);

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NPORT = 2;

  // Flattened view of the architectural registers; slot 0 is hard-wired to 0
  // so x0 needs no storage and reads naturally return zero.
  logic [NREGS*XLEN-1:0] rf_flat;
  assign rf_flat[XLEN-1:0] = '0;

  // One-hot write select. Address 0 never decodes, so x0 writes vanish here.
  logic [NREGS-1:0] wr_sel;

  // Decode the MEM/WB destination into a per-register write strobe.
  always_comb begin
    wr_sel = '0;
    if (i_rd_wr && (i_rd_addr != '0)) begin
      wr_sel[i_rd_addr] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one 32-bit register per architectural x1..x31. The reset is
  // asynchronous and must clear every entry at once, so the array is built
  // from individual flops rather than a RAM macro.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] x_q;
      logic [XLEN-1:0] x_d;

      // Hold the value unless this entry is the decoded write target.
      always_comb begin
        x_d = x_q;
        if (wr_sel[gi]) begin
          x_d = i_ALUout;
        end
      end

      // Register update; reset clears the entry without waiting for clk.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
        end else begin
          x_q <= x_d;
        end
      end

      assign rf_flat[gi*XLEN +: XLEN] = x_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read ports: both ports share the same resolution rules and are fully
  // independent, so they are generated from one template.
  // ---------------------------------------------------------------------
  logic [NPORT*AW-1:0]   rs_addr_flat;
  logic [NPORT*XLEN-1:0] rs_data_flat;

  assign rs_addr_flat = {i_rs2_addr, i_rs1_addr};

  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic [AW+4:0]   base;

      assign addr = rs_addr_flat[gi*AW +: AW];
      // Bit offset of the addressed entry within rf_flat (addr * 32).
      assign base = {addr, 5'd0};

      // x0 reads zero; a matching in-flight write wins over stored contents
      // so decode sees the value that is being committed this very cycle.
      always_comb begin
        data = rf_flat[base +: XLEN];
        if (addr == '0) begin
          data = '0;
        end else if (i_rd_wr && (i_rd_addr == addr)) begin
          data = i_ALUout;
        end
      end

      assign rs_data_flat[gi*XLEN +: XLEN] = data;
    end
  endgenerate

  assign o_rs1_data = rs_data_flat[0 +: XLEN];
  assign o_rs2_data = rs_data_flat[XLEN +: XLEN];

  // ---------------------------------------------------------------------
  // Retired-instruction counter. Anything but a bubble retires, whether or
  // not it writes a register; the 64-bit add wraps naturally.
  // ---------------------------------------------------------------------
  logic [63:0] instret_q;
  logic [63:0] instret_d;

  // Advance by one for each non-bubble MEM/WB beat.
  always_comb begin
    instret_d = instret_q;
    if (i_mnemonic != NOP_MNEMONIC) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Counter state; cleared asynchronously with the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign o_instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural model (register array
// plus retire count) is checked against the DUT every cycle, and directed
// literal expectations pin the model itself.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [5:0]  i_mnemonic;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_ALUout;
  logic        i_rd_wr;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic [63:0] o_instret;

  wb_regfile #(.NOP_MNEMONIC(6'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mnemonic (i_mnemonic),
    .i_rd_addr  (i_rd_addr),
    .i_ALUout   (i_ALUout),
    .i_rd_wr    (i_rd_wr),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
    .o_instret  (o_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Model state
  logic [31:0]     m_regs [32];
  longint unsigned m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read resolution straight from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_rd_wr && i_rd_addr == a) return i_ALUout;
    return m_regs[a];
  endfunction

  // Model update: clears on reset, commits writes and counts retirements.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0;
    end else begin
      if (i_rd_wr && i_rd_addr != 5'd0) m_regs[i_rd_addr] = i_ALUout;
      if (i_mnemonic != 6'd0) m_cnt = m_cnt + 1;
    end
  end

  // Compare process: checks all outputs mid-cycle after inputs settle.
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("model_rs1", {32'd0, o_rs1_data}, {32'd0, exp_rd(i_rs1_addr)});
      chk("model_rs2", {32'd0, o_rs2_data}, {32'd0, exp_rd(i_rs2_addr)});
      chk("model_instret", o_instret, m_cnt);
    end
  end

  // Drive one MEM/WB beat plus decode addresses at the falling edge.
  task automatic beat(input logic [5:0] mn, input logic [4:0] rd, input logic [31:0] d,
                      input logic wr, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    i_mnemonic = mn;
    i_rd_addr  = rd;
    i_ALUout   = d;
    i_rd_wr    = wr;
    i_rs1_addr = r1;
    i_rs2_addr = r2;
    $display("[TB] beat mn=%0d rd=x%0d data=%h wr=%0b rs1=x%0d rs2=x%0d", mn, rd, d, wr, r1, r2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    i_mnemonic = 6'd0;
    i_rd_addr  = 5'd0;
    i_ALUout   = 32'd0;
    i_rd_wr    = 1'b0;
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    #1;
    chk("reset_instret", o_instret, 64'd0);

    // Preload x5, then assert reset between edges.
    beat(6'd1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    #1;
    chk("preload_x5", {32'd0, o_rs1_data}, 64'h0000_0000_DEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_x5", {32'd0, o_rs1_data}, 64'd0);
    chk("async_rst_instret", o_instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read x7.
    beat(6'd1, 5'd7, 32'h1234_5678, 1'b1, 5'd0, 5'd0);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    #1;
    chk("read_x7", {32'd0, o_rs1_data}, 64'h0000_0000_1234_5678);

    // x0 writes are discarded, x0 always reads 0.
    beat(6'd1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
    #1;
    chk("x0_bypass_rs1", {32'd0, o_rs1_data}, 64'd0);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("x0_rs1", {32'd0, o_rs1_data}, 64'd0);
    chk("x0_rs2", {32'd0, o_rs2_data}, 64'd0);

    // Bypass: disabled write shows old x9, enabled write shows new value.
    beat(6'd1, 5'd9, 32'h1111_2222, 1'b1, 5'd0, 5'd0);
    beat(6'd0, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd9, 5'd9);
    #1;
    chk("nobypass_rs1", {32'd0, o_rs1_data}, 64'h0000_0000_1111_2222);
    chk("nobypass_rs2", {32'd0, o_rs2_data}, 64'h0000_0000_1111_2222);
    beat(6'd1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd9, 5'd9);
    #1;
    chk("bypass_rs1", {32'd0, o_rs1_data}, 64'h0000_0000_A5A5_A5A5);
    chk("bypass_rs2", {32'd0, o_rs2_data}, 64'h0000_0000_A5A5_A5A5);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0);
    #1;
    chk("after_bypass_x9", {32'd0, o_rs1_data}, 64'h0000_0000_A5A5_A5A5);

    // Disabled write to x3 over 5 cycles.
    beat(6'd1, 5'd3, 32'h3333_3333, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      beat(6'd0, 5'd3, 32'h0000_0055, 1'b0, 5'd3, 5'd3);
      #1;
      chk("disabled_x3", {32'd0, o_rs1_data}, 64'h0000_0000_3333_3333);
    end
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    #1;
    chk("disabled_x3_final", {32'd0, o_rs1_data}, 64'h0000_0000_3333_3333);

    // Fill every register, reading neighbours as they change.
    for (int i = 1; i < 32; i++) begin
      beat(6'd2, 5'(i), 32'h0101_0101 * 32'(i), 1'b1, 5'(i), 5'(i - 1));
    end
    for (int i = 0; i < 32; i++) begin
      beat(6'd0, 5'd0, 32'd0, 1'b0, 5'(i), 5'(31 - i));
    end
    #1;
    chk("fill_x31", {32'd0, o_rs1_data}, 64'h0000_0000_1F1F_1F1F);
    chk("fill_x0", {32'd0, o_rs2_data}, 64'd0);

    // Retire count: 10 beats alternating bubble / mnemonic 4.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beat((i % 2 == 1) ? 6'd4 : 6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    end
    #1;
    chk("instret_lag", o_instret, 64'd4);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("instret_5", o_instret, 64'd5);

    // Wrap: preset the counter near the top, then retire three.
    @(negedge clk);
    i_mnemonic = 6'd0;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    #3;
    release dut.instret_q;
    beat(6'd7, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("wrap_preset", o_instret, 64'hFFFF_FFFF_FFFF_FFFE);
    beat(6'd7, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("wrap_max", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    beat(6'd7, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("wrap_zero", o_instret, 64'd0);
    beat(6'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("wrap_one", o_instret, 64'd1);

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
